// File: rtl/imm_pkg.sv
// Shared types and constants for the handshaked RISC-V immediate generator.
// The format encoding matches the imm_src field driven by the control unit.
package imm_pkg;

   typedef enum logic [2:0] {
      IMM_I   = 3'b000,
      IMM_S   = 3'b001,
      IMM_B   = 3'b010,
      IMM_J   = 3'b011,
      IMM_U   = 3'b100,
      IMM_Z   = 3'b101,
      IMM_SH  = 3'b110,
      IMM_ILL = 3'b111
   } imm_fmt_e;

   localparam int XLEN_32 = 32;
   localparam int XLEN_64 = 64;

   function automatic bit xlen_legal(input int x);
      return (x == XLEN_32) || (x == XLEN_64);
   endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate builder: instr[31:7] + format select -> XLEN immediate.
// Every format is assembled directly at XLEN width, so no bits are computed and discarded.
module imm_decode
   import imm_pkg::*;
#(
   parameter int XLEN = XLEN_32
) (
   input  logic [24:0]     instr,
   input  logic [2:0]      imm_src,
   output logic [XLEN-1:0] imm_ext,
   output logic            imm_err
);

   // Indexed with full instruction-word bit numbers so the formats read like the ISA manual.
   logic [31:7] w;
   assign w = instr;

   always_comb begin
      imm_ext = '0;
      imm_err = 1'b0;
      case (imm_fmt_e'(imm_src))
         IMM_I:  imm_ext = {{(XLEN-11){w[31]}}, w[30:20]};
         IMM_S:  imm_ext = {{(XLEN-11){w[31]}}, w[30:25], w[11:7]};
         IMM_B:  imm_ext = {{(XLEN-12){w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
         IMM_J:  imm_ext = {{(XLEN-20){w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
         IMM_U:  imm_ext = {{(XLEN-31){w[31]}}, w[30:12], 12'b0};
         IMM_Z:  imm_ext = {{(XLEN-5){1'b0}}, w[19:15]};
         IMM_SH: begin
            if (XLEN == XLEN_64) imm_ext = {{(XLEN-6){1'b0}}, w[25:20]};
            else                 imm_ext = {{(XLEN-5){1'b0}}, w[24:20]};
         end
         default: imm_err = 1'b1;
      endcase
   end

endmodule

// File: rtl/imm_ext_pipe.sv
// Handshaked immediate generator with one or two register stages and a synchronous flush.
// The decode always feeds the output register; STAGES=2 adds a raw-instruction stage ahead of it.
module imm_ext_pipe
   import imm_pkg::*;
#(
   parameter int XLEN   = XLEN_32,
   parameter int STAGES = 1
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [24:0]     instr,
   input  logic [2:0]      imm_src,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] imm_ext,
   output logic            imm_err
);

   if (!xlen_legal(XLEN)) begin : g_bad_xlen
      $fatal(1, "imm_ext_pipe: XLEN must be 32 or 64");
   end
   if (STAGES != 1 && STAGES != 2) begin : g_bad_stages
      $fatal(1, "imm_ext_pipe: STAGES must be 1 or 2");
   end

   // Handshake: a stage moves an entry when its valid and the downstream ready are both high
   // at a rising edge; a valid output holds its data until taken, and a stage may refill in
   // the same cycle it drains. flush clears every valid bit but never gates in_ready.
   logic            feed_valid;
   logic [24:0]     dec_instr;
   logic [2:0]      dec_src;
   logic [XLEN-1:0] dec_imm;
   logic            dec_err;
   logic            out_valid_q;
   logic [XLEN-1:0] imm_q;
   logic            err_q;
   logic            s1_ready;

   assign s1_ready = !out_valid_q || out_ready;

   if (STAGES == 2) begin : g_two
      logic        s0_valid;
      logic [24:0] s0_instr;
      logic [2:0]  s0_src;

      assign in_ready   = !s0_valid || s1_ready;
      assign feed_valid = s0_valid;
      assign dec_instr  = s0_instr;
      assign dec_src    = s0_src;

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            s0_valid <= 1'b0;
            s0_instr <= '0;
            s0_src   <= '0;
         end else if (flush) begin
            s0_valid <= 1'b0;
         end else if (in_ready) begin
            s0_valid <= in_valid;
            if (in_valid) begin
               s0_instr <= instr;
               s0_src   <= imm_src;
            end
         end
      end
   end else begin : g_one
      assign in_ready   = s1_ready;
      assign feed_valid = in_valid;
      assign dec_instr  = instr;
      assign dec_src    = imm_src;
   end

   imm_decode #(.XLEN(XLEN)) u_decode (
      .instr   (dec_instr),
      .imm_src (dec_src),
      .imm_ext (dec_imm),
      .imm_err (dec_err)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid_q <= 1'b0;
         imm_q       <= '0;
         err_q       <= 1'b0;
      end else if (flush) begin
         out_valid_q <= 1'b0;
      end else if (s1_ready) begin
         out_valid_q <= feed_valid;
         if (feed_valid) begin
            imm_q <= dec_imm;
            err_q <= dec_err;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign imm_ext   = imm_q;
   assign imm_err   = err_q;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Bench for imm_ext_pipe: dut_a is XLEN=32/STAGES=1, dut_b is XLEN=64/STAGES=2.
// Accepted inputs push model results into per-DUT queues; a monitor checks every valid output.
module tb_imm_ext_pipe;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_err;
   logic [24:0] a_instr;
   logic [2:0]  a_src;
   logic [31:0] a_imm;

   logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_err;
   logic [24:0] b_instr;
   logic [2:0]  b_src;
   logic [63:0] b_imm;

   int n_tests = 0;
   int n_fail  = 0;
   logic [64:0] exp_q_a[$];
   logic [64:0] exp_q_b[$];

   imm_ext_pipe #(.XLEN(32), .STAGES(1)) dut_a (
      .clk(clk), .reset_n(reset_n), .flush(a_flush),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .instr(a_instr), .imm_src(a_src),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .imm_ext(a_imm), .imm_err(a_err)
   );

   imm_ext_pipe #(.XLEN(64), .STAGES(2)) dut_b (
      .clk(clk), .reset_n(reset_n), .flush(b_flush),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .instr(b_instr), .imm_src(b_src),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .imm_ext(b_imm), .imm_err(b_err)
   );

   // Reference model: the immediate as a signed/unsigned integer value, then truncated to XLEN.
   function automatic logic [64:0] ref_imm(input logic [31:0] w, input logic [2:0] s, input int xlen);
      longint      v;
      logic        err;
      logic [11:0] t12;
      logic [12:0] t13;
      logic [20:0] t21;
      logic [31:0] t32;
      v   = 0;
      err = 1'b0;
      case (s)
         3'd0: begin t12 = w[31:20];                               v = longint'($signed(t12)); end
         3'd1: begin t12 = {w[31:25], w[11:7]};                    v = longint'($signed(t12)); end
         3'd2: begin t13 = {w[31], w[7], w[30:25], w[11:8], 1'b0}; v = longint'($signed(t13)); end
         3'd3: begin t21 = {w[31], w[19:12], w[20], w[30:21], 1'b0}; v = longint'($signed(t21)); end
         3'd4: begin t32 = {w[31:12], 12'b0};                      v = longint'($signed(t32)); end
         3'd5: v = longint'(w[19:15]);
         3'd6: v = (xlen == 64) ? longint'(w[25:20]) : longint'(w[24:20]);
         default: begin v = 0; err = 1'b1; end
      endcase
      if (xlen == 32) v = v & 64'h0000_0000_FFFF_FFFF;
      return {err, v};
   endfunction

   function automatic logic [31:0] itype(input int imm);
      logic [31:0] w;
      w = {imm[11:0], 5'd0, 3'd0, 5'd1, 7'h13};
      return w;
   endfunction

   task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor/scoreboard, sampling 1 time unit before each rising edge.
   initial forever begin
      @(negedge clk);
      #4;
      if (reset_n) begin
         if (a_out_valid) begin
            if (exp_q_a.size() == 0) chk("a_out_without_entry", exp_q_a.size(), 1);
            else begin
               chk("a_out", {a_err, 32'h0, a_imm}, exp_q_a[0]);
               if (a_out_ready) void'(exp_q_a.pop_front());
            end
         end
         if (a_flush) exp_q_a.delete();
         else if (a_in_valid && a_in_ready) exp_q_a.push_back(ref_imm({a_instr, 7'h0}, a_src, 32));

         if (b_out_valid) begin
            if (exp_q_b.size() == 0) chk("b_out_without_entry", exp_q_b.size(), 1);
            else begin
               chk("b_out", {b_err, b_imm}, exp_q_b[0]);
               if (b_out_ready) void'(exp_q_b.pop_front());
            end
         end
         if (b_flush) exp_q_b.delete();
         else if (b_in_valid && b_in_ready) exp_q_b.push_back(ref_imm({b_instr, 7'h0}, b_src, 64));
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1, "watchdog");
   end

   // Driver tasks: called at a falling edge, return at the falling edge after acceptance.
   task automatic send_a(input logic [31:0] w, input logic [2:0] s);
      logic acc;
      int   n;
      acc = 1'b0;
      n   = 0;
      a_in_valid = 1'b1; a_instr = w[31:7]; a_src = s;
      while (!acc && n < 50) begin
         #4;
         acc = a_in_ready;
         @(negedge clk);
         n++;
      end
      a_in_valid = 1'b0;
      if (!acc) chk("a_send_timeout", acc, 1);
   endtask

   task automatic send_b(input logic [31:0] w, input logic [2:0] s);
      logic acc;
      int   n;
      acc = 1'b0;
      n   = 0;
      b_in_valid = 1'b1; b_instr = w[31:7]; b_src = s;
      while (!acc && n < 50) begin
         #4;
         acc = b_in_ready;
         @(negedge clk);
         n++;
      end
      b_in_valid = 1'b0;
      if (!acc) chk("b_send_timeout", acc, 1);
   endtask

   task automatic b_directed(input string name, input logic [31:0] w, input logic [2:0] s,
                             input logic [64:0] e);
      send_b(w, s);
      chk({name, "_lat_empty"}, b_out_valid, 0);
      @(negedge clk);
      chk({name, "_valid"}, b_out_valid, 1);
      chk(name, {b_err, b_imm}, e);
   endtask

   initial begin
      logic [63:0] got[$];
      int          got_cyc[$];
      logic [31:0] wk;
      int          k;
      int          n_out;

      reset_n = 1'b0;
      a_flush = 0; a_in_valid = 0; a_instr = '0; a_src = '0; a_out_ready = 0;
      b_flush = 0; b_in_valid = 0; b_instr = '0; b_src = '0; b_out_ready = 0;

      // Reset values, during and after reset
      #2;
      chk("rst_a_valid", a_out_valid, 0);
      chk("rst_b_valid", b_out_valid, 0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      chk("rst_a_valid_post", a_out_valid, 0);
      chk("rst_a_imm", {a_err, a_imm}, 0);
      chk("rst_b_valid_post", b_out_valid, 0);
      chk("rst_b_imm", {b_err, b_imm}, 0);

      // STAGES=1, XLEN=32: latency 1 and I/B/J formats
      a_out_ready = 1'b1;
      send_a(32'hFFF0_0093, 3'd0);
      chk("a_lat1_valid", a_out_valid, 1);
      chk("a_i_imm", a_imm, 32'hFFFF_FFFF);
      send_a(32'hFE00_0EE3, 3'd2);
      chk("a_b_imm", a_imm, 32'hFFFF_FFFC);
      send_a(32'h0080_006F, 3'd3);
      chk("a_j_imm", a_imm, 32'h0000_0008);
      @(negedge clk);

      // STAGES=2, XLEN=64: latency 2 and I/U/Z/SH/illegal formats
      b_out_ready = 1'b1;
      b_directed("b_i", 32'hFFF0_0093, 3'd0, {1'b0, 64'hFFFF_FFFF_FFFF_FFFF});
      b_directed("b_u", 32'h8000_02B7, 3'd4, {1'b0, 64'hFFFF_FFFF_8000_0000});
      b_directed("b_z", 32'h000F_D073, 3'd5, {1'b0, 64'h0000_0000_0000_001F});
      b_directed("b_sh", 32'h03F0_1013, 3'd6, {1'b0, 64'h0000_0000_0000_003F});
      b_directed("b_ill", 32'hFFF0_0093, 3'd7, {1'b1, 64'h0});
      @(negedge clk);

      // Backpressure on STAGES=2: four entries, consumer stalled for six cycles
      b_out_ready = 1'b0;
      b_src = 3'd0;
      k = 1;
      for (int c = 0; c < 12; c++) begin
         if (c == 6) b_out_ready = 1'b1;
         wk = itype(k);
         b_in_valid = (k <= 4);
         b_instr = wk[31:7];
         #4;
         if (c == 5) begin
            chk("bp_accepts", k - 1, 2);
            chk("bp_in_ready", b_in_ready, 0);
            chk("bp_hold", b_imm, 64'd1);
         end
         if (b_out_valid && b_out_ready) begin
            got.push_back(b_imm);
            got_cyc.push_back(c);
         end
         if (b_in_valid && b_in_ready) k++;
         @(negedge clk);
      end
      b_in_valid = 1'b0;
      chk("bp_count", got.size(), 4);
      for (int i = 0; i < got.size(); i++) begin
         chk("bp_order", got[i], i + 1);
         chk("bp_cycle", got_cyc[i], 6 + i);
      end

      // Flush STAGES=2 with both stages full and an input offered
      b_out_ready = 1'b0;
      send_b(itype(5), 3'd0);
      send_b(itype(6), 3'd0);
      wk = itype(7);
      b_flush = 1'b1; b_in_valid = 1'b1; b_instr = wk[31:7]; b_out_ready = 1'b1;
      #4;
      chk("b_flush_in_ready", b_in_ready, 1);
      @(negedge clk);
      b_flush = 1'b0; b_in_valid = 1'b0;
      chk("b_flush_valid", b_out_valid, 0);
      @(negedge clk);
      chk("b_flush_drop", b_out_valid, 0);

      // Flush STAGES=1 while the output drains and a new input is offered
      a_out_ready = 1'b0;
      send_a(itype(9), 3'd0);
      wk = itype(10);
      a_flush = 1'b1; a_in_valid = 1'b1; a_instr = wk[31:7]; a_out_ready = 1'b1;
      #4;
      chk("a_flush_in_ready", a_in_ready, 1);
      @(negedge clk);
      a_flush = 1'b0; a_in_valid = 1'b0;
      chk("a_flush_valid", a_out_valid, 0);

      // Asynchronous reset with valid entries held in both DUTs
      a_out_ready = 1'b0; b_out_ready = 1'b0;
      send_a(itype(11), 3'd0);
      send_b(itype(12), 3'd0);
      @(negedge clk);
      chk("rst_pre_a", a_out_valid, 1);
      chk("rst_pre_b", b_out_valid, 1);
      @(posedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      chk("rst_async_a", a_out_valid, 0);
      chk("rst_async_b", b_out_valid, 0);
      chk("rst_async_b_imm", b_imm, 64'd0);
      exp_q_a.delete();
      exp_q_b.delete();
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      // Throughput on STAGES=1: eight back-to-back transfers
      a_out_ready = 1'b1;
      n_out = 0;
      for (int c = 0; c <= 8; c++) begin
         wk = $urandom();
         a_in_valid = (c < 8);
         a_instr = wk[31:7];
         a_src = 3'($urandom_range(0, 7));
         #4;
         if (c < 8) chk("tp_in_ready", a_in_ready, 1);
         if (c >= 1 && a_out_valid) n_out++;
         @(negedge clk);
      end
      a_in_valid = 1'b0;
      chk("tp_results", n_out, 8);

      // Random traffic with backpressure and occasional flushes on both DUTs
      for (int c = 0; c < 600; c++) begin
         wk = $urandom();
         a_in_valid = 1'($urandom_range(0, 1));
         a_instr = wk[31:7];
         a_src = 3'($urandom_range(0, 7));
         a_out_ready = ($urandom_range(0, 3) != 0);
         a_flush = ($urandom_range(0, 31) == 0);
         wk = $urandom();
         b_in_valid = 1'($urandom_range(0, 1));
         b_instr = wk[31:7];
         b_src = 3'($urandom_range(0, 7));
         b_out_ready = ($urandom_range(0, 3) != 0);
         b_flush = ($urandom_range(0, 31) == 0);
         @(negedge clk);
      end

      // Drain: every accepted entry must have emerged
      a_in_valid = 0; a_flush = 0; a_out_ready = 1;
      b_in_valid = 0; b_flush = 0; b_out_ready = 1;
      repeat (5) @(negedge clk);
      chk("a_drain", exp_q_a.size(), 0);
      chk("b_drain", exp_q_b.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/imm_ext_pipe.md
Name: imm_ext_pipe

Overview:
- Parametrised, handshaked immediate generator for the multicycle RISC-V datapath.
- Captures `instr[31:7]` plus an immediate-format select and builds the sign- or zero-extended immediate at XLEN width.
- Holds the result in an output register until the consumer (ALU source mux / PC-target adder) takes it.
- Adds U-type, CSR zimm and shift-amount formats, an illegal-format flag, a flush, and an optional second pipeline stage.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- STAGES, 1, register stages from input to output; legal values 1 or 2.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous clear of all in-flight entries.
- in_valid  input  1  instr/imm_src are valid this cycle.
- in_ready  output  1  block accepts input this cycle.
- instr  input  25  instruction bits [31:7].
- imm_src  input  3  immediate format select.
- out_valid  output  1  imm_ext/imm_err are valid.
- out_ready  input  1  consumer accepts output this cycle.
- imm_ext  output  XLEN  extended immediate.
- imm_err  output  1  entry carried an illegal imm_src.

Behaviour:
- Reset (reset_n low, asynchronous): all stage valid bits = 0, imm_ext = 0, imm_err = 0. Outputs stay at these values until the first accepted transfer completes.
- Handshake:
  - A transfer occurs on a cycle where valid && ready.
  - out_valid, imm_ext and imm_err stay stable while out_valid && !out_ready.
  - in_valid may drop without being accepted.
- Format encoding. Sign bit is instr[31] unless stated; all ranges refer to the full instruction word.
  - 000 I: sext(instr[31:20]).
  - 001 S: sext({instr[31:25], instr[11:7]}).
  - 010 B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - 011 J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - 100 U: sext({instr[31:12], 12'b0}). At XLEN=64, bits 63:32 copy instr[31].
  - 101 Z (CSR zimm): zext(instr[19:15]).
  - 110 SH (shamt): zext(instr[24:20]) when XLEN=32; zext(instr[25:20]) when XLEN=64.
  - 111: illegal. imm_ext = 0 and imm_err = 1. The entry still travels through the pipeline and handshakes normally.
- STAGES=1:
  - Single output register.
  - in_ready = !out_valid || out_ready (combinational pass-through of out_ready).
  - Latency 1: an input accepted at edge N is on the outputs after edge N.
  - Simultaneous drain and accept: the new value replaces the old one, giving full throughput of 1 per cycle.
- STAGES=2:
  - Stage 0 registers the raw instr and imm_src. Stage 1 registers the extended result.
  - stage1_ready = !s1_valid || out_ready.
  - in_ready = !s0_valid || stage1_ready.
  - Latency 2 cycles, throughput 1 per cycle, no bubbles when out_ready is held high.
- Full condition: all stages valid and out_ready = 0. in_ready = 0 and nothing is overwritten.
- Flush:
  - On the next edge, all valid bits are cleared; imm_ext and imm_err keep their last data (don't-care while invalid).
  - flush overrides a simultaneous input accept: that input is dropped.
  - in_ready is not gated by flush.
- Reset asserted mid-transfer: state returns to reset values immediately; no partial output.
- Any XLEN or STAGES value outside the legal set must cause an elaboration-time fatal error.

Decomposition:
- Shared package imm_pkg holds:
  - enum imm_fmt_e (IMM_I, IMM_S, IMM_B, IMM_J, IMM_U, IMM_Z, IMM_SH, IMM_ILL) as a 3-bit type;
  - localparams for the legal XLEN values.
- One combinational sub-module, imm_decode (instr, imm_src -> imm_ext, imm_err, parametrised by XLEN).
- imm_ext_pipe instantiates imm_decode once. The decode sits ahead of the output register: after stage 0 when STAGES=2, directly at the input when STAGES=1.

Test Plan:
- Reset values and I-type:
  - Stimulus: reset_n low, then release. Check out_valid=0, imm_ext=0.
  - Stimulus: STAGES=1, instr word 0xFFF00093 (addi x1,x0,-1), imm_src=000, out_ready=1.
  - Response: after 1 cycle, out_valid=1 and imm_ext=0xFFFFFFFF; at XLEN=64, 0xFFFFFFFFFFFFFFFF.
- B-type and J-type:
  - B: word 0xFE000EE3, imm_src=010 -> imm_ext=0xFFFFFFFC (-4).
  - J: word 0x0080006F, imm_src=011 -> imm_ext=0x00000008.
- U, Z, SH and illegal, at XLEN=64:
  - U: word 0x800002B7, imm_src=100 -> 0xFFFFFFFF80000000.
  - Z: word 0x000FD073, imm_src=101 -> 0x1F.
  - SH: word 0x03F01013, imm_src=110 -> 0x3F.
  - Illegal: imm_src=111 -> imm_ext=0, imm_err=1.
- Backpressure, STAGES=2:
  - Stimulus: stream 4 I-type entries with immediates 1, 2, 3, 4 while out_ready=0.
  - Response: in_ready falls after 2 accepts; outputs stay stable at 1.
  - Stimulus: raise out_ready.
  - Response: 1, 2, 3, 4 emerge in order on consecutive cycles; nothing lost or duplicated.
- Flush and reset:
  - Flush with both stages full and in_valid=1 -> out_valid=0 next cycle; the input is dropped.
  - reset_n pulsed low mid-stream -> out_valid=0 asynchronously, before the next clk edge.
- Throughput, STAGES=1:
  - Stimulus: in_valid=1 and out_ready=1 continuously for 8 cycles.
  - Response: 8 results on 8 consecutive cycles; in_ready stays 1 throughout.
